// File: rtl/half_add.sv
// Registered, width-parameterised bitwise half adder.
// Each lane computes sum = a ^ b and carry = a & b. There is no carry chain between lanes.
// Results are captured when in_valid is high and held otherwise.
// Optional feature: define HALF_ADD_CARRY_COUNT_EN to add the carry_cnt output.
// carry_cnt is the registered population count of the carry vector.
module half_add #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] c_out,
  output logic             out_valid,
`ifdef HALF_ADD_CARRY_COUNT_EN
  output logic             carry_any,
  output logic [$clog2(WIDTH+1)-1:0] carry_cnt
`else
  output logic             carry_any
`endif
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] c_out_d, c_out_q;
  logic             out_valid_d, out_valid_q;
  logic             carry_any_d, carry_any_q;

  // Next-state: capture a new sample only when qualified, otherwise hold.
  // The hold path never looks at a/b, so X on idle operands cannot leak through.
  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    carry_any_d = carry_any_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d       = a ^ b;
      c_out_d     = a & b;
      carry_any_d = |(a & b);
    end
  end

  // State register; the synchronous reset overrides in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      c_out_q     <= '0;
      out_valid_q <= 1'b0;
      carry_any_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      carry_any_q <= carry_any_d;
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;
  assign carry_any = carry_any_q;

`ifdef HALF_ADD_CARRY_COUNT_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0] carry_cnt_d, carry_cnt_q;
  logic [WIDTH-1:0] carry_vec;

  assign carry_vec = a & b;

  // Population count of the lane carries, taken from the same sample as c_out.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (in_valid) begin
      carry_cnt_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        carry_cnt_d = carry_cnt_d + CntW'(carry_vec[i]);
      end
    end
  end

  // Count register, same reset and hold rules as c_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt_q <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_half_add.sv
// Directed, table-driven bench for half_add.
// An 8-lane and a 1-lane instance share the stimulus. The 1-lane instance is checked
// against lane 0 of the 8-lane expectations.
module tb_half_add;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic [7:0] sum8, c8;
  logic       ov8, ca8;
  logic [0:0] sum1, c1;
  logic       ov1, ca1;
`ifdef HALF_ADD_CARRY_COUNT_EN
  logic [3:0] cnt8;
  logic [0:0] cnt1;
`endif

  int n_vec;
  int n_err;

  half_add #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum8),
    .c_out     (c8),
    .out_valid (ov8),
`ifdef HALF_ADD_CARRY_COUNT_EN
    .carry_any (ca8),
    .carry_cnt (cnt8)
`else
    .carry_any (ca8)
`endif
  );

  half_add #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .sum       (sum1),
    .c_out     (c1),
    .out_valid (ov1),
`ifdef HALF_ADD_CARRY_COUNT_EN
    .carry_any (ca1),
    .carry_cnt (cnt1)
`else
    .carry_any (ca1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_sum;
    logic [7:0] e_c;
    logic       e_ov;
    logic       e_ca;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one input set, let one edge pass, then compare both instances.
  task automatic apply(input vec_t v);
    rst      = v.rst;
    in_valid = v.vld;
    a        = v.a;
    b        = v.b;
    @(posedge clk);
    #1;
    chk({v.name, ".sum8"}, sum8, v.e_sum);
    chk({v.name, ".c8"}, c8, v.e_c);
    chk({v.name, ".ov8"}, {7'd0, ov8}, {7'd0, v.e_ov});
    chk({v.name, ".ca8"}, {7'd0, ca8}, {7'd0, v.e_ca});
    chk({v.name, ".sum1"}, {7'd0, sum1}, {7'd0, v.e_sum[0]});
    chk({v.name, ".c1"}, {7'd0, c1}, {7'd0, v.e_c[0]});
    chk({v.name, ".ov1"}, {7'd0, ov1}, {7'd0, v.e_ov});
    chk({v.name, ".ca1"}, {7'd0, ca1}, {7'd0, v.e_c[0]});
`ifdef HALF_ADD_CARRY_COUNT_EN
    chk({v.name, ".cnt8"}, {4'd0, cnt8}, {4'd0, v.e_cnt});
    chk({v.name, ".cnt1"}, {7'd0, cnt1}, {7'd0, v.e_c[0]});
    chk({v.name, ".cnt_any"}, {7'd0, (cnt8 != 4'd0)}, {7'd0, ca8});
`endif
  endtask

  initial begin
    vec_t v;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'h01;
    b        = 8'h01;

    //            name      rst   vld   a      b      sum    c      ov    ca    cnt
    tbl.push_back('{"rst0", 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{"rst1", 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{"tt00a", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{"tt00b", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{"tt01a", 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{"tt01b", 1'b0, 1'b1, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{"tt10a", 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{"tt10b", 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{"tt11a", 1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 1'b1, 4'd1});
    tbl.push_back('{"tt11b", 1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 1'b1, 4'd1});
    // Hold: idle operands all-ones must not disturb the captured result.
    tbl.push_back('{"hold0", 1'b0, 1'b1, 8'hF0, 8'h3C, 8'hCC, 8'h30, 1'b1, 1'b1, 4'd2});
    tbl.push_back('{"hold1", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hCC, 8'h30, 1'b0, 1'b1, 4'd2});
    tbl.push_back('{"hold2", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hCC, 8'h30, 1'b0, 1'b1, 4'd2});
    tbl.push_back('{"hold3", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hCC, 8'h30, 1'b0, 1'b1, 4'd2});
    // Lane independence: no ripple out of lane 0.
    tbl.push_back('{"lane", 1'b0, 1'b1, 8'hFF, 8'h01, 8'hFE, 8'h01, 1'b1, 1'b1, 4'd1});
    tbl.push_back('{"cnt4", 1'b0, 1'b1, 8'hFF, 8'hAA, 8'h55, 8'hAA, 1'b1, 1'b1, 4'd4});
    tbl.push_back('{"cnt0", 1'b0, 1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b1, 1'b0, 4'd0});
    // Mid-stream reset on the third sample.
    tbl.push_back('{"ms1", 1'b0, 1'b1, 8'h12, 8'h34, 8'h26, 8'h10, 1'b1, 1'b1, 4'd1});
    tbl.push_back('{"ms2", 1'b0, 1'b1, 8'h56, 8'h78, 8'h2E, 8'h50, 1'b1, 1'b1, 4'd2});
    tbl.push_back('{"ms3rst", 1'b1, 1'b1, 8'h9A, 8'hBC, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{"ms4", 1'b0, 1'b1, 8'hDE, 8'hF0, 8'h2E, 8'hD0, 1'b1, 1'b1, 4'd3});
    // X on idle operands must be ignored.
    tbl.push_back('{"xidle", 1'b0, 1'b0, 8'hxx, 8'hxx, 8'h2E, 8'hD0, 1'b0, 1'b1, 4'd3});
    // Reset while a result is held clears it; idle afterwards keeps zeros.
    tbl.push_back('{"rsthld", 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{"idle0", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0});

    foreach (tbl[i]) apply(tbl[i]);

    // Back-to-back stream of pseudo-random samples against a small model.
    for (int i = 0; i < 16; i++) begin
      v.name = "rnd";
      v.rst  = 1'b0;
      v.vld  = 1'b1;
      v.a    = 8'($urandom_range(0, 255));
      v.b    = 8'($urandom_range(0, 255));
      v.e_sum = v.a ^ v.b;
      v.e_c   = v.a & v.b;
      v.e_ov  = 1'b1;
      v.e_ca  = (v.e_c != 8'h00);
      v.e_cnt = 4'($countones(v.e_c));
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/half_add.md
Name: half_add

Overview:
Registered, width-parameterised bitwise half adder. Each bit lane computes sum = a XOR b and carry = a AND b. Results are captured on the clock edge behind a simple valid qualifier. Used as a leaf arithmetic primitive feeding wider adder/compare logic in the datapath.

Parameters:
WIDTH, 1, number of independent half-adder lanes (legal range 1..64).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  qualifies a/b this cycle.
a  input  WIDTH  operand A, one bit per lane.
b  input  WIDTH  operand B, one bit per lane.
sum  output  WIDTH  registered per-lane sum (a XOR b).
c_out  output  WIDTH  registered per-lane carry (a AND b).
out_valid  output  1  high for exactly one cycle per accepted input.
carry_any  output  1  registered OR-reduction of c_out.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. It has priority over in_valid.
- Values after reset: sum=0, c_out=0, out_valid=0, carry_any=0.
- Latency is 1 cycle. If in_valid=1 at edge N, then sum, c_out and carry_any reflect that a/b from edge N onward, and out_valid=1 for the cycle after edge N.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - sum, c_out and carry_any hold their previous values. They are not cleared.
- Back-to-back in_valid=1 is accepted every cycle, giving full throughput. There is no backpressure and no ready signal.
- Lanes are fully independent. There is no carry propagation between lanes; carry from lane i never affects lane i+1.
- carry_any is computed from the same a/b sample as c_out: OR of (a AND b) over all lanes. It updates and holds under the same rules as c_out.
- Reset asserted while a valid result is held: the next edge clears all outputs, including out_valid, and that result is lost.
- X on a/b while in_valid=0 must not disturb any output.
- Per-lane truth table (a,b -> sum,c_out): 00->00, 01->10, 10->10, 11->01.

Optional Feature:
Macro HALF_ADD_CARRY_COUNT_EN.
- When defined, add output carry_cnt, width clog2(WIDTH+1), minimum 1 bit.
  - It is the registered population count of (a AND b) for the accepted sample.
  - It is 0 on reset and holds when in_valid=0, with the same timing as c_out.
  - It is always consistent with carry_any: carry_any == (carry_cnt != 0).
- When not defined, the carry_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1, a=1, b=1 -> sum=0, c_out=0, out_valid=0, carry_any=0 throughout.
2. Truth table, WIDTH=1: apply (0,0),(0,1),(1,0),(1,1), each with in_valid=1 for 2 consecutive cycles. Each result appears one cycle later: sum/c_out = 0/0, 1/0, 1/0, 0/1. out_valid=1 every cycle; carry_any=1 only for (1,1).
3. Hold: WIDTH=8, a=0xF0, b=0x3C valid, then in_valid=0 with a=0xFF, b=0xFF for 3 cycles -> sum=0xCC, c_out=0x30, carry_any=1 stay held; out_valid=1 once, then 0.
4. Lane independence: WIDTH=8, a=0xFF, b=0x01 -> sum=0xFE, c_out=0x01. There is no ripple into bit 1.
5. Mid-stream reset: stream 4 valid samples and assert rst on the 3rd edge -> outputs 0 on the following cycle, out_valid=0. Stream resumes normally after rst drops.
6. With HALF_ADD_CARRY_COUNT_EN, WIDTH=8:
   - a=0xFF, b=0xAA -> carry_cnt=4, carry_any=1.
   - a=0x0F, b=0xF0 -> carry_cnt=0, carry_any=0.
